// File: rtl/rst_decrypt.sv
// rst_decrypt: decryption side of the RST rotating-table substitution cipher.
// A 12-char key is latched and checked one char per cycle (alphanumeric and
// unique, case-sensitive). Each accepted ciphertext pair {row_hdr, col_hdr}
// is mapped back to one plaintext char through the 6x6 body. After every
// successful decode the headers rotate one position.
module rst_decrypt #(
  parameter int UPPER_OUT  = 0,
  parameter int CHK_CYCLES = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [95:0] key_in,
  input  logic        key_load,
  input  logic [15:0] ctxt_in,
  input  logic        ctxt_valid,
  output logic        ctxt_ready,
  output logic [7:0]  ptxt_out,
  output logic        ptxt_valid,
  input  logic        ptxt_ready,
  output logic        err_invalid_key,
  output logic        err_key_not_installed,
  output logic        err_invalid_ctxt
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CHECK   = 3'd1,
    KEY_ERR = 3'd2,
    READY   = 3'd3,
    DECODE  = 3'd4,
    OUT     = 3'd5
  } state_t;

  localparam logic [3:0] CHK_LAST = 4'(CHK_CYCLES - 1);

  state_t      state_r;
  logic [95:0] key_r;
  logic [2:0]  rot_r;
  logic [3:0]  chk_idx_r;
  logic        chk_fail_r;
  logic [15:0] ctxt_r;

  logic [7:0]  k_s [12];
  logic [7:0]  row_hdr_s [6];
  logic [7:0]  col_hdr_s [6];
  logic [7:0]  cur_k_s;
  logic        dup_s;
  logic        cur_bad_s;
  logic        row_hit_s;
  logic        col_hit_s;
  logic [2:0]  row_pos_s;
  logic [2:0]  col_pos_s;
  logic [5:0]  idx_s;
  logic [7:0]  char_s;
  logic        load_s;
  logic [2:0]  rot_next_s;

  // True for [0-9], [A-Z] and [a-z].
  function automatic logic is_alnum(input logic [7:0] c);
    logic ok;
    if ((c >= 8'h30) && (c <= 8'h39)) begin
      ok = 1'b1;
    end else if ((c >= 8'h41) && (c <= 8'h5A)) begin
      ok = 1'b1;
    end else if ((c >= 8'h61) && (c <= 8'h7A)) begin
      ok = 1'b1;
    end else begin
      ok = 1'b0;
    end
    return ok;
  endfunction

  // Current 0-based slot of a header that started at 0-based slot p, after n rotations.
  function automatic logic [2:0] rotate(input logic [2:0] p, input logic [2:0] n);
    logic [3:0] s;
    s = {1'b0, p} + {1'b0, n};
    if (s >= 4'd6) begin
      s = s - 4'd6;
    end else begin
      s = s;
    end
    return s[2:0];
  endfunction

  // Body cell contents: 26 letters then 10 digits, row-major.
  function automatic logic [7:0] cell_char(input logic [5:0] idx);
    logic [7:0] base;
    logic [7:0] c;
    base = (UPPER_OUT != 0) ? 8'h41 : 8'h61;
    if (idx < 6'd26) begin
      c = base + {2'b00, idx};
    end else begin
      c = 8'h30 + {2'b00, idx} - 8'd26;
    end
    return c;
  endfunction

  // Unpack key chars and build the unrotated row/column header tables.
  always_comb begin
    for (int i = 0; i < 12; i++) begin
      k_s[i] = key_r[95 - 8*i -: 8];
    end
    row_hdr_s[0] = k_s[0];  col_hdr_s[0] = k_s[1];
    row_hdr_s[1] = k_s[10]; col_hdr_s[1] = k_s[11];
    row_hdr_s[2] = k_s[2];  col_hdr_s[2] = k_s[3];
    row_hdr_s[3] = k_s[8];  col_hdr_s[3] = k_s[9];
    row_hdr_s[4] = k_s[4];  col_hdr_s[4] = k_s[5];
    row_hdr_s[5] = k_s[6];  col_hdr_s[5] = k_s[7];
  end

  // Validity of the key char under check this cycle (charset and uniqueness).
  always_comb begin
    cur_k_s = k_s[chk_idx_r];
    dup_s   = 1'b0;
    for (int j = 0; j < 12; j++) begin
      if ((4'(j) != chk_idx_r) && (k_s[j] == cur_k_s)) begin
        dup_s = 1'b1;
      end else begin
        dup_s = dup_s;
      end
    end
    cur_bad_s = dup_s || !is_alnum(cur_k_s);
  end

  // Header lookup for the latched pair and resulting plaintext char.
  always_comb begin
    row_hit_s = 1'b0;
    col_hit_s = 1'b0;
    row_pos_s = 3'd0;
    col_pos_s = 3'd0;
    for (int p = 0; p < 6; p++) begin
      if (!row_hit_s && (ctxt_r[15:8] == row_hdr_s[p])) begin
        row_hit_s = 1'b1;
        row_pos_s = 3'(p);
      end else begin
        row_hit_s = row_hit_s;
      end
      if (!col_hit_s && (ctxt_r[7:0] == col_hdr_s[p])) begin
        col_hit_s = 1'b1;
        col_pos_s = 3'(p);
      end else begin
        col_hit_s = col_hit_s;
      end
    end
    idx_s  = ({3'b000, rotate(row_pos_s, rot_r)} * 6'd6) + {3'b000, rotate(col_pos_s, rot_r)};
    char_s = cell_char(idx_s);
  end

  // Key-load qualification and rotation counter successor.
  always_comb begin
    load_s = key_load && ((state_r == IDLE) || (state_r == KEY_ERR) || (state_r == READY));
    if (rot_r == 3'd5) begin
      rot_next_s = 3'd0;
    end else begin
      rot_next_s = rot_r + 3'd1;
    end
  end

  // Control FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r               <= IDLE;
      key_r                 <= 96'd0;
      rot_r                 <= 3'd0;
      chk_idx_r             <= 4'd0;
      chk_fail_r            <= 1'b0;
      ctxt_r                <= 16'd0;
      ctxt_ready            <= 1'b0;
      ptxt_out              <= 8'd0;
      ptxt_valid            <= 1'b0;
      err_invalid_key       <= 1'b0;
      err_key_not_installed <= 1'b1;
      err_invalid_ctxt      <= 1'b0;
    end else begin
      err_invalid_ctxt <= 1'b0;
      if (load_s) begin
        key_r                 <= key_in;
        rot_r                 <= 3'd0;
        chk_idx_r             <= 4'd0;
        chk_fail_r            <= 1'b0;
        err_invalid_key       <= 1'b0;
        err_key_not_installed <= 1'b0;
        ctxt_ready            <= 1'b0;
        ptxt_valid            <= 1'b0;
        state_r               <= CHECK;
      end else begin
        case (state_r)
          CHECK: begin
            if (chk_idx_r == CHK_LAST) begin
              if (chk_fail_r || cur_bad_s) begin
                err_invalid_key <= 1'b1;
                state_r         <= KEY_ERR;
              end else begin
                ctxt_ready <= 1'b1;
                state_r    <= READY;
              end
            end else begin
              chk_idx_r  <= chk_idx_r + 4'd1;
              chk_fail_r <= chk_fail_r || cur_bad_s;
            end
          end
          READY: begin
            if (ctxt_valid) begin
              ctxt_r     <= ctxt_in;
              ctxt_ready <= 1'b0;
              state_r    <= DECODE;
            end else begin
              state_r <= READY;
            end
          end
          DECODE: begin
            if (row_hit_s && col_hit_s) begin
              ptxt_out   <= char_s;
              ptxt_valid <= 1'b1;
              state_r    <= OUT;
            end else begin
              err_invalid_ctxt <= 1'b1;
              ctxt_ready       <= 1'b1;
              state_r          <= READY;
            end
          end
          OUT: begin
            if (ptxt_ready) begin
              ptxt_valid <= 1'b0;
              rot_r      <= rot_next_s;
              ctxt_ready <= 1'b1;
              state_r    <= READY;
            end else begin
              state_r <= OUT;
            end
          end
          IDLE, KEY_ERR: begin
            state_r <= state_r;
          end
          default: begin
            ctxt_ready <= 1'b0;
            ptxt_valid <= 1'b0;
            state_r    <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rst_decrypt.sv
// Directed testbench for rst_decrypt with hand-computed expectations.
// Key "abcdefghijkl": rows a,k,c,i,e,g / cols b,l,d,j,f,h.
module tb_rst_decrypt;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [95:0] key_in;
  logic        key_load;
  logic [15:0] ctxt_in;
  logic        ctxt_valid;
  logic        ctxt_ready;
  logic [7:0]  ptxt_out;
  logic        ptxt_valid;
  logic        ptxt_ready;
  logic        err_invalid_key;
  logic        err_key_not_installed;
  logic        err_invalid_ctxt;

  int checks = 0;
  int errors = 0;

  localparam logic [95:0] KEY_GOOD = "abcdefghijkl";

  always #5 clk = ~clk;

  rst_decrypt #(.UPPER_OUT(0), .CHK_CYCLES(12)) dut (
    .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_load(key_load),
    .ctxt_in(ctxt_in), .ctxt_valid(ctxt_valid), .ctxt_ready(ctxt_ready),
    .ptxt_out(ptxt_out), .ptxt_valid(ptxt_valid), .ptxt_ready(ptxt_ready),
    .err_invalid_key(err_invalid_key), .err_key_not_installed(err_key_not_installed),
    .err_invalid_ctxt(err_invalid_ctxt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [95:0] k);
    key_in = k; key_load = 1'b1; tick(); key_load = 1'b0;
    repeat (12) tick();
  endtask

  // Send one pair and sample the cycle after acceptance.
  task automatic xfer(input logic [15:0] pair, output bit to, output logic v,
                      output logic [7:0] c, output logic e);
    int n = 0;
    to = 1'b0;
    while ((ctxt_ready !== 1'b1) && (n < 50)) begin tick(); n++; end
    if (ctxt_ready !== 1'b1) to = 1'b1;
    ctxt_in = pair; ctxt_valid = 1'b1; tick(); ctxt_valid = 1'b0; tick();
    v = ptxt_valid; c = ptxt_out; e = err_invalid_ctxt;
  endtask

  task automatic consume();
    ptxt_ready = 1'b1; tick(); ptxt_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; key_in = 96'd0; key_load = 1'b0; ctxt_in = 16'd0;
    ctxt_valid = 1'b0; ptxt_ready = 1'b0;
    repeat (3) tick();
    checks++; if (ctxt_ready !== 1'b0) begin errors++; $display("FAIL reset_ctxt_ready got %b exp 0", ctxt_ready); end
    checks++; if (ptxt_valid !== 1'b0) begin errors++; $display("FAIL reset_ptxt_valid got %b exp 0", ptxt_valid); end
    checks++; if (ptxt_out !== 8'h00) begin errors++; $display("FAIL reset_ptxt_out got %h exp 00", ptxt_out); end
    checks++; if (err_invalid_key !== 1'b0) begin errors++; $display("FAIL reset_err_key got %b exp 0", err_invalid_key); end
    checks++; if (err_key_not_installed !== 1'b1) begin errors++; $display("FAIL reset_not_inst got %b exp 1", err_key_not_installed); end
    checks++; if (err_invalid_ctxt !== 1'b0) begin errors++; $display("FAIL reset_err_ctxt got %b exp 0", err_invalid_ctxt); end
    rst_n = 1'b1;
    ctxt_in = "ab"; ctxt_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if ((ctxt_ready !== 1'b0) || (ptxt_valid !== 1'b0)) begin
        errors++; $display("FAIL idle_ignore got ready %b valid %b exp 0 0", ctxt_ready, ptxt_valid);
      end
    end
    ctxt_valid = 1'b0;
    checks++; if (err_key_not_installed !== 1'b1) begin errors++; $display("FAIL idle_not_inst got %b exp 1", err_key_not_installed); end
  endtask

  task automatic test_basic();
    bit to; logic v; logic [7:0] c; logic e;
    load_key(KEY_GOOD);
    checks++; if ((err_invalid_key !== 1'b0) || (err_key_not_installed !== 1'b0)) begin
      errors++; $display("FAIL basic_flags got %b%b exp 00", err_invalid_key, err_key_not_installed);
    end
    checks++; if (ctxt_ready !== 1'b1) begin errors++; $display("FAIL basic_ready got %b exp 1", ctxt_ready); end
    xfer("ab", to, v, c, e);
    checks++; if (to || (v !== 1'b1) || (c !== "a") || (e !== 1'b0)) begin
      errors++; $display("FAIL basic_ab got to %0d v %b c %h e %b exp 0 1 61 0", to, v, c, e);
    end
    checks++; if (ctxt_ready !== 1'b0) begin errors++; $display("FAIL basic_out_ready got %b exp 0", ctxt_ready); end
    consume();
    checks++; if ((ptxt_valid !== 1'b0) || (ctxt_ready !== 1'b1)) begin
      errors++; $display("FAIL basic_consume got v %b r %b exp 0 1", ptxt_valid, ctxt_ready);
    end
    xfer("ab", to, v, c, e);
    checks++; if (to || (v !== 1'b1) || (c !== "h")) begin
      errors++; $display("FAIL basic_rot1 got to %0d v %b c %h exp 0 1 68", to, v, c);
    end
    consume();
  endtask

  task automatic test_rotation();
    bit to; logic v; logic [7:0] c; logic e;
    logic [7:0] exp_c [7];
    exp_c = '{"a", "h", "o", "v", "2", "9", "a"};
    load_key(KEY_GOOD);
    for (int i = 0; i < 7; i++) begin
      xfer("ab", to, v, c, e);
      checks++; if (to || (v !== 1'b1) || (c !== exp_c[i])) begin
        errors++; $display("FAIL rot_%0d got to %0d v %b c %h exp 0 1 %h", i, to, v, c, exp_c[i]);
      end
      consume();
    end
  endtask

  task automatic test_bad_header();
    bit to; logic v; logic [7:0] c; logic e;
    logic [15:0] bad [3];
    bad = '{"zz", "ax", "Ab"};
    load_key(KEY_GOOD);
    xfer("gh", to, v, c, e);
    checks++; if (to || (v !== 1'b1) || (c !== "9")) begin
      errors++; $display("FAIL hdr_gh got to %0d v %b c %h exp 0 1 39", to, v, c);
    end
    consume();
    for (int i = 0; i < 3; i++) begin
      xfer(bad[i], to, v, c, e);
      checks++; if (to || (v !== 1'b0) || (e !== 1'b1)) begin
        errors++; $display("FAIL hdr_bad_%0d got to %0d v %b e %b exp 0 0 1", i, to, v, e);
      end
      tick();
      checks++; if (err_invalid_ctxt !== 1'b0) begin errors++; $display("FAIL hdr_pulse_%0d got %b exp 0", i, err_invalid_ctxt); end
    end
    xfer("ab", to, v, c, e);
    checks++; if (to || (v !== 1'b1) || (c !== "h")) begin
      errors++; $display("FAIL hdr_after_err got to %0d v %b c %h exp 0 1 68", to, v, c);
    end
    consume();
  endtask

  task automatic test_bad_key();
    logic [95:0] keys [4];
    logic        exp_err [4];
    keys    = '{"aacdefghijkl", "abcdefghij!l", "abcdefghijka", "aAcdefghijkl"};
    exp_err = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      key_in = keys[i]; key_load = 1'b1; tick(); key_load = 1'b0;
      repeat (11) tick();
      checks++; if ((err_invalid_key !== 1'b0) || (ctxt_ready !== 1'b0)) begin
        errors++; $display("FAIL key_%0d_in_check got err %b r %b exp 0 0", i, err_invalid_key, ctxt_ready);
      end
      tick();
      checks++; if ((err_invalid_key !== exp_err[i]) || (ctxt_ready !== !exp_err[i])) begin
        errors++; $display("FAIL key_%0d_result got err %b r %b exp %b %b", i, err_invalid_key, ctxt_ready, exp_err[i], !exp_err[i]);
      end
      if (exp_err[i]) begin
        ctxt_in = "ab"; ctxt_valid = 1'b1;
        repeat (3) tick();
        ctxt_valid = 1'b0;
        checks++; if ((ctxt_ready !== 1'b0) || (ptxt_valid !== 1'b0) || (err_invalid_key !== 1'b1)) begin
          errors++; $display("FAIL key_%0d_blocked got r %b v %b err %b exp 0 0 1", i, ctxt_ready, ptxt_valid, err_invalid_key);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    bit to; logic v; logic [7:0] c; logic e;
    load_key(KEY_GOOD);
    xfer("ab", to, v, c, e);
    checks++; if (to || (v !== 1'b1) || (c !== "a")) begin
      errors++; $display("FAIL bp_first got to %0d v %b c %h exp 0 1 61", to, v, c);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if ((ptxt_valid !== 1'b1) || (ptxt_out !== "a") || (ctxt_ready !== 1'b0)) begin
        errors++; $display("FAIL bp_hold_%0d got v %b c %h r %b exp 1 61 0", i, ptxt_valid, ptxt_out, ctxt_ready);
      end
    end
    consume();
    xfer("ab", to, v, c, e);
    checks++; if (to || (v !== 1'b1) || (c !== "h")) begin
      errors++; $display("FAIL bp_rot_once got to %0d v %b c %h exp 0 1 68", to, v, c);
    end
    consume();
  endtask

  task automatic test_reset_in_out();
    bit to; logic v; logic [7:0] c; logic e;
    load_key(KEY_GOOD);
    xfer("ab", to, v, c, e);
    checks++; if (to || (v !== 1'b1)) begin errors++; $display("FAIL rst_pre got to %0d v %b exp 0 1", to, v); end
    rst_n = 1'b0;
    #2;
    checks++; if ((ptxt_valid !== 1'b0) || (err_key_not_installed !== 1'b1) || (ctxt_ready !== 1'b0)) begin
      errors++; $display("FAIL rst_async got v %b ni %b r %b exp 0 1 0", ptxt_valid, err_key_not_installed, ctxt_ready);
    end
    rst_n = 1'b1;
    ctxt_in = "ab"; ctxt_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if ((ctxt_ready !== 1'b0) || (ptxt_valid !== 1'b0)) begin
        errors++; $display("FAIL rst_ignore_%0d got r %b v %b exp 0 0", i, ctxt_ready, ptxt_valid);
      end
    end
    ctxt_valid = 1'b0;
    load_key(KEY_GOOD);
    xfer("ab", to, v, c, e);
    checks++; if (to || (v !== 1'b1) || (c !== "a")) begin
      errors++; $display("FAIL rst_reload got to %0d v %b c %h exp 0 1 61", to, v, c);
    end
    consume();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rotation();
    test_bad_header();
    test_bad_key();
    test_backpressure();
    test_reset_in_out();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
